// File: rtl/id_ex_pipeline_register.sv
// ID/EX boundary register of the 5-stage MIPS pipeline.
// It captures the decoded fields and the register read data from Instruction
// Decode and presents them to Execute one cycle later. It also contains the
// load-use hazard detector and a small FSM. The FSM remembers a branch flush
// that arrives while Execute is holding.
// Optional build macro: HAZARD_STATS_EN adds the saturating stall_count output.
// Reset is asynchronous and active-low on the port "reset".
module id_ex_pipeline_register #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_read_data1,
    input  logic [DATA_W-1:0]     id_read_data2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_read_data1,
    output logic [DATA_W-1:0]     ex_read_data2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [CTRL_W-1:0]     ex_ctrl
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    // Bit position of memRead inside the packed control word.
    localparam int CTRL_MEMREAD = 1;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_HOLD       = 2'd1,
        S_HOLD_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d;
    logic [REG_ADDR_W-1:0] rt_q, rt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     data1_q, data1_d;
    logic [DATA_W-1:0]     data2_q, data2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;

    logic hazard;
    logic flush_pending;

    // A load in EX whose destination is read by the instruction in ID.
    // A load to $0 is excluded, because $0 is never written.
    always_comb begin
        hazard = valid_q & ctrl_q[CTRL_MEMREAD] & (rt_q != '0) & id_valid &
                 ((rt_q == id_rs) | (rt_q == id_rt));
    end

    // A flush applies now if it arrives this cycle or was remembered during a hold.
    always_comb begin
        flush_pending = flush | (state_q == S_HOLD_FLUSH);
    end

    // Upstream stall. A flush makes the hazard moot, because the
    // dependent instruction is wrong-path.
    always_comb begin
        stall = ex_hold | (hazard & ~flush & (state_q != S_HOLD_FLUSH));
    end

    // Next state and next EX contents. The branches are checked in priority order:
    // hold, then flush, then hazard, then normal load.
    always_comb begin
        state_d = S_RUN;
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;

        if (ex_hold) begin
            state_d = flush_pending ? S_HOLD_FLUSH : S_HOLD;
        end else if (flush_pending || hazard) begin
            state_d = S_RUN;
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            ctrl_d  = '0;
        end else begin
            state_d = S_RUN;
            valid_d = id_valid;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            data1_d = id_read_data1;
            data2_d = id_read_data2;
            imm_d   = id_imm;
            ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    // EX stage registers and FSM state. Reset clears everything immediately,
    // including any flush that was pending during a hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_read_data1 = data1_q;
    assign ex_read_data2 = data2_q;
    assign ex_imm        = imm_q;
    assign ex_ctrl       = ctrl_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Count cycles with stall asserted. The count saturates instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Stall counter register. Only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule
